// File: rtl/wb_stage_regfile.sv
// Writeback stage with a small architectural register file.
// It selects the writeback value and performs register writes with write-through bypass.
// It also keeps the retired-instruction counter, the WWD output latch and the sticky halt flag.
module wb_stage_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [1:0]        wb_reg_dst,
  input  logic              wb_reg_write,
  input  logic [1:0]        wb_src,
  input  logic              wb_is_wwd,
  input  logic              wb_is_halt,
  input  logic [1:0]        rd_addr1,
  input  logic [1:0]        rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [DATA_W-1:0] num_inst,
  output logic [DATA_W-1:0] output_port,
  output logic              is_halted
);

  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_PC  = 2'd2;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] num_inst_q, num_inst_d;
  logic [DATA_W-1:0] output_port_q, output_port_d;
  logic              is_halted_q, is_halted_d;
  logic              retire;
  logic              wwd_fire;

  // Writeback source mux; the reserved encoding falls back to the ALU result.
  always_comb begin
    wb_data = wb_alu_result;
    case (wb_src)
      SRC_MEM: wb_data = wb_mem_data;
      SRC_PC:  wb_data = wb_pc;
      default: wb_data = wb_alu_result;
    endcase
  end

  // A HLT retires (and is counted) but suppresses its own register write and WWD effect.
  assign retire   = wb_valid & ~is_halted_q;
  assign wb_we    = retire & wb_reg_write & ~wb_is_halt;
  assign wwd_fire = retire & wb_is_wwd & ~wb_is_halt;

  // Write-through bypass, so ID sees the value being written in this very cycle.
  assign rd_data1 = (wb_we && (rd_addr1 == wb_reg_dst)) ? wb_data : regs_q[rd_addr1];
  assign rd_data2 = (wb_we && (rd_addr2 == wb_reg_dst)) ? wb_data : regs_q[rd_addr2];

  // Next-state for the register file: only the addressed entry changes.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wb_we) begin
      regs_d[wb_reg_dst] = wb_data;
    end
  end

  // Next-state for the counter, the output latch and the halt flag.
  always_comb begin
    num_inst_d    = num_inst_q;
    output_port_d = output_port_q;
    is_halted_d   = is_halted_q;
    if (retire) begin
      num_inst_d = num_inst_q + DATA_W'(1);
      if (wb_is_halt) begin
        is_halted_d = 1'b1;
      end
    end
    if (wwd_fire) begin
      output_port_d = wb_alu_result;
    end
  end

  // State registers; reset wins over any retire in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      num_inst_q    <= '0;
      output_port_q <= '0;
      is_halted_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      num_inst_q    <= num_inst_d;
      output_port_q <= output_port_d;
      is_halted_q   <= is_halted_d;
    end
  end

  assign num_inst    = num_inst_q;
  assign output_port = output_port_q;
  assign is_halted   = is_halted_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Bench for wb_stage_regfile: directed scenarios plus randomized cycles against an ISA-level model.
module tb_wb_stage_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_valid;
  logic [15:0] wb_pc, wb_mem_data, wb_alu_result;
  logic [1:0]  wb_reg_dst;
  logic        wb_reg_write;
  logic [1:0]  wb_src;
  logic        wb_is_wwd, wb_is_halt;
  logic [1:0]  rd_addr1, rd_addr2;
  logic [15:0] rd_data1, rd_data2, wb_data, num_inst, output_port;
  logic        wb_we, is_halted;

  int checks = 0;
  int failures = 0;

  // Architectural model state
  logic [15:0] m_regs [4];
  logic [15:0] m_cnt, m_out;
  logic        m_halt;

  wb_stage_regfile #(.DATA_W(16), .NUM_REGS(4)) dut (
    .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result),
    .wb_reg_dst(wb_reg_dst), .wb_reg_write(wb_reg_write), .wb_src(wb_src),
    .wb_is_wwd(wb_is_wwd), .wb_is_halt(wb_is_halt),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .wb_data(wb_data), .wb_we(wb_we),
    .num_inst(num_inst), .output_port(output_port), .is_halted(is_halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_wb_data();
    if (wb_src == 2'd1) return wb_mem_data;
    if (wb_src == 2'd2) return wb_pc;
    return wb_alu_result;
  endfunction

  function automatic logic exp_we();
    return wb_valid && !m_halt && wb_reg_write && !wb_is_halt;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [1:0] a);
    if (exp_we() && a == wb_reg_dst) return exp_wb_data();
    return m_regs[a];
  endfunction

  task automatic idle();
    reset_n = 1'b1; wb_valid = 1'b0; wb_pc = '0; wb_mem_data = '0; wb_alu_result = '0;
    wb_reg_dst = '0; wb_reg_write = 1'b0; wb_src = '0; wb_is_wwd = 1'b0; wb_is_halt = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0;
  endtask

  // One clock edge; the model applies the same instruction the DUT sees at this edge.
  task automatic tick();
    logic [15:0] d;
    @(posedge clk);
    d = exp_wb_data();
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_cnt = '0; m_out = '0; m_halt = 1'b0;
    end else if (wb_valid && !m_halt) begin
      m_cnt = m_cnt + 16'd1;
      if (wb_is_halt) m_halt = 1'b1;
      else begin
        if (wb_reg_write) m_regs[wb_reg_dst] = d;
        if (wb_is_wwd) m_out = wb_alu_result;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); reset_n = 1'b0;
    tick(); tick();
    idle();
    #1;
    checks++; if (num_inst !== 16'h0) begin failures++; $display("FAIL reset_num_inst got=%h exp=0000", num_inst); end
    checks++; if (output_port !== 16'h0) begin failures++; $display("FAIL reset_output_port got=%h exp=0000", output_port); end
    checks++; if (is_halted !== 1'b0) begin failures++; $display("FAIL reset_is_halted got=%b exp=0", is_halted); end
    for (int a = 0; a < 4; a++) begin
      rd_addr1 = 2'(a); rd_addr2 = 2'(3 - a); #1;
      checks++; if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0) begin
        failures++; $display("FAIL reset_regs addr=%0d got=%h/%h exp=0000", a, rd_data1, rd_data2);
      end
    end
  endtask

  task automatic test_write_bypass();
    idle();
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_reg_dst = 2'd1; wb_src = 2'd0;
    wb_alu_result = 16'h1234; wb_mem_data = 16'h9999; rd_addr1 = 2'd1; rd_addr2 = 2'd2; #1;
    checks++; if (rd_data1 !== 16'h1234) begin failures++; $display("FAIL bypass_rd1 got=%h exp=1234", rd_data1); end
    checks++; if (rd_data2 !== 16'h0000) begin failures++; $display("FAIL nobypass_rd2 got=%h exp=0000", rd_data2); end
    checks++; if (wb_we !== 1'b1 || wb_data !== 16'h1234) begin failures++; $display("FAIL write_we_data got=%b/%h exp=1/1234", wb_we, wb_data); end
    tick();
    idle(); rd_addr2 = 2'd1; #1;
    checks++; if (rd_data2 !== 16'h1234) begin failures++; $display("FAIL write_reg1 got=%h exp=1234", rd_data2); end
    checks++; if (num_inst !== 16'd1) begin failures++; $display("FAIL write_count got=%0d exp=1", num_inst); end
  endtask

  task automatic test_load_jal();
    logic [15:0] base;
    base = m_cnt;
    idle(); wb_valid = 1'b1; wb_reg_write = 1'b1; wb_reg_dst = 2'd2; wb_src = 2'd1;
    wb_mem_data = 16'hBEEF; wb_alu_result = 16'h1111; wb_pc = 16'h2222;
    tick();
    idle(); rd_addr1 = 2'd2; #1;
    checks++; if (rd_data1 !== 16'hBEEF) begin failures++; $display("FAIL load_reg2 got=%h exp=beef", rd_data1); end
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_reg_dst = 2'd2; wb_src = 2'd2;
    wb_pc = 16'h0031; wb_mem_data = 16'h4444; wb_alu_result = 16'h5555; #1;
    checks++; if (wb_data !== 16'h0031) begin failures++; $display("FAIL jal_wb_data got=%h exp=0031", wb_data); end
    tick();
    idle(); rd_addr1 = 2'd2; #1;
    checks++; if (rd_data1 !== 16'h0031) begin failures++; $display("FAIL jal_reg2 got=%h exp=0031", rd_data1); end
    checks++; if (num_inst !== base + 16'd2) begin failures++; $display("FAIL load_jal_count got=%h exp=%h", num_inst, base + 16'd2); end
    // reserved source encoding behaves like the ALU result
    wb_src = 2'd3; wb_alu_result = 16'hA0A0; wb_mem_data = 16'h0B0B; wb_pc = 16'h0C0C; #1;
    checks++; if (wb_data !== 16'hA0A0) begin failures++; $display("FAIL src3_wb_data got=%h exp=a0a0", wb_data); end
  endtask

  task automatic test_wwd();
    logic [15:0] base;
    base = m_cnt;
    idle(); wb_valid = 1'b1; wb_is_wwd = 1'b1; wb_alu_result = 16'h00A5;
    tick();
    idle(); wb_is_wwd = 1'b1; wb_alu_result = 16'hFFFF; #1;
    checks++; if (output_port !== 16'h00A5) begin failures++; $display("FAIL wwd_port got=%h exp=00a5", output_port); end
    tick(); idle(); #1;
    checks++; if (output_port !== 16'h00A5) begin failures++; $display("FAIL wwd_bubble_port got=%h exp=00a5", output_port); end
    checks++; if (num_inst !== base + 16'd1) begin failures++; $display("FAIL wwd_count got=%h exp=%h", num_inst, base + 16'd1); end
    // WWD combined with a register write: both effects land together
    wb_valid = 1'b1; wb_is_wwd = 1'b1; wb_reg_write = 1'b1; wb_reg_dst = 2'd3; wb_alu_result = 16'h3C3C;
    tick(); idle(); rd_addr1 = 2'd3; #1;
    checks++; if (output_port !== 16'h3C3C || rd_data1 !== 16'h3C3C) begin
      failures++; $display("FAIL wwd_and_write got=%h/%h exp=3c3c/3c3c", output_port, rd_data1);
    end
  endtask

  task automatic test_halt();
    logic [15:0] base, r0, r3;
    base = m_cnt; r0 = m_regs[0]; r3 = m_regs[3];
    idle(); wb_valid = 1'b1; wb_is_halt = 1'b1; wb_reg_write = 1'b1; wb_is_wwd = 1'b1;
    wb_reg_dst = 2'd3; wb_alu_result = 16'h5A5A; rd_addr1 = 2'd3; #1;
    checks++; if (wb_we !== 1'b0 || rd_data1 !== r3) begin failures++; $display("FAIL halt_we got=%b/%h exp=0/%h", wb_we, rd_data1, r3); end
    tick();
    idle(); wb_valid = 1'b1; wb_reg_write = 1'b1; wb_reg_dst = 2'd0; wb_alu_result = 16'h7777; wb_is_wwd = 1'b1;
    rd_addr1 = 2'd0; rd_addr2 = 2'd3; #1;
    checks++; if (is_halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", is_halted); end
    checks++; if (wb_we !== 1'b0 || rd_data1 !== r0) begin failures++; $display("FAIL halted_we got=%b/%h exp=0/%h", wb_we, rd_data1, r0); end
    tick(); #1;
    checks++; if (rd_data1 !== r0 || rd_data2 !== r3) begin failures++; $display("FAIL halted_regs got=%h/%h exp=%h/%h", rd_data1, rd_data2, r0, r3); end
    checks++; if (num_inst !== base + 16'd1) begin failures++; $display("FAIL halt_count got=%h exp=%h", num_inst, base + 16'd1); end
    checks++; if (output_port === 16'h5A5A || output_port === 16'h7777) begin failures++; $display("FAIL halt_port got=%h exp=%h", output_port, m_out); end
  endtask

  task automatic test_wrap_and_reset();
    idle(); reset_n = 1'b0; tick();
    idle(); wb_valid = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    idle(); #1;
    checks++; if (num_inst !== 16'hFFFF) begin failures++; $display("FAIL preload_count got=%h exp=ffff", num_inst); end
    wb_valid = 1'b1; tick(); idle(); #1;
    checks++; if (num_inst !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h exp=0000", num_inst); end
    // write, WWD, then halt; then reset coinciding with a retire
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_is_wwd = 1'b1; wb_reg_dst = 2'd1; wb_alu_result = 16'hCAFE; tick();
    idle(); wb_valid = 1'b1; wb_is_halt = 1'b1; tick();
    idle(); reset_n = 1'b0; wb_valid = 1'b1; wb_reg_write = 1'b1; wb_reg_dst = 2'd1; wb_is_wwd = 1'b1; wb_alu_result = 16'hDEAD;
    tick();
    idle(); rd_addr1 = 2'd1; #1;
    checks++; if (num_inst !== 16'h0 || output_port !== 16'h0 || is_halted !== 1'b0 || rd_data1 !== 16'h0) begin
      failures++; $display("FAIL reset_over_retire got=%h/%h/%b/%h exp=0000/0000/0/0000", num_inst, output_port, is_halted, rd_data1);
    end
    // first cycle after reset release accepts a retire
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_reg_dst = 2'd1; wb_alu_result = 16'h0042; tick();
    idle(); rd_addr1 = 2'd1; #1;
    checks++; if (num_inst !== 16'd1 || rd_data1 !== 16'h0042) begin failures++; $display("FAIL post_reset_retire got=%h/%h exp=0001/0042", num_inst, rd_data1); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset_n       = ($urandom_range(0, 40) != 0);
      wb_valid      = ($urandom_range(0, 3) != 0);
      wb_pc         = 16'($urandom);
      wb_mem_data   = 16'($urandom);
      wb_alu_result = 16'($urandom);
      wb_reg_dst    = 2'($urandom);
      wb_reg_write  = 1'($urandom);
      wb_src        = 2'($urandom);
      wb_is_wwd     = ($urandom_range(0, 3) == 0);
      wb_is_halt    = ($urandom_range(0, 30) == 0);
      rd_addr1      = 2'($urandom);
      rd_addr2      = 2'($urandom);
      #1;
      checks++;
      if (wb_data !== exp_wb_data() || wb_we !== exp_we() || rd_data1 !== exp_rd(rd_addr1) ||
          rd_data2 !== exp_rd(rd_addr2) || num_inst !== m_cnt || output_port !== m_out || is_halted !== m_halt) begin
        failures++;
        $display("FAIL random_cycle n=%0d got wbd=%h we=%b rd1=%h rd2=%h cnt=%h out=%h h=%b exp wbd=%h we=%b rd1=%h rd2=%h cnt=%h out=%h h=%b",
                 n, wb_data, wb_we, rd_data1, rd_data2, num_inst, output_port, is_halted,
                 exp_wb_data(), exp_we(), exp_rd(rd_addr1), exp_rd(rd_addr2), m_cnt, m_out, m_halt);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_cnt = '0; m_out = '0; m_halt = 1'b0;
    idle(); reset_n = 1'b0;
    test_reset();
    test_write_bypass();
    test_load_jal();
    test_wwd();
    test_halt();
    test_reset();
    test_random();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage_regfile.md
WB_STAGE_REGFILE -- requirements
Module: wb_stage_regfile

Interface
REQ-001 Parameter DATA_W, default 16, datapath and register width.
REQ-002 Parameter NUM_REGS, default 4, architectural register count; the register address is 2 bits.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 wb_valid  input  1  MEM/WB register holds a real, non-bubble instruction.
REQ-006 wb_pc  input  16  return address (already PC+1) carried by MEM/WB.
REQ-007 wb_mem_data  input  16  load data from MEM/WB.
REQ-008 wb_alu_result  input  16  ALU result from MEM/WB; carries the $rs value for WWD.
REQ-009 wb_reg_dst  input  2  destination register index.
REQ-010 wb_reg_write  input  1  instruction writes the register file.
REQ-011 wb_src  input  2  writeback source: 0 = alu_result, 1 = mem_data, 2 = pc, 3 = reserved (treated as 0).
REQ-012 wb_is_wwd  input  1  instruction is WWD.
REQ-013 wb_is_halt  input  1  instruction is HLT.
REQ-014 rd_addr1, rd_addr2  input  2 each  ID-stage read addresses.
REQ-015 rd_data1, rd_data2  output  16 each  read data, with bypass.
REQ-016 wb_data  output  16  selected writeback value, combinational, for the forwarding unit.
REQ-017 wb_we  output  1  effective write enable this cycle, combinational.
REQ-018 num_inst  output  16  retired-instruction counter, registered.
REQ-019 output_port  output  16  WWD output latch, registered.
REQ-020 is_halted  output  1  sticky halt flag, registered.

Function
REQ-021 wb_data SHALL be selected by wb_src every cycle, regardless of wb_valid.
REQ-022 Definitions: retire = wb_valid & !is_halted; wb_we = retire & wb_reg_write & !wb_is_halt.
REQ-023 When wb_we=1 at posedge, regs[wb_reg_dst] SHALL take wb_data; all other registers SHALL hold.
REQ-024 rd_dataN SHALL equal wb_data when wb_we=1 and rd_addrN==wb_reg_dst (write-through bypass); otherwise rd_dataN SHALL equal regs[rd_addrN]. Reads are combinational.
REQ-025 On each retire, num_inst SHALL increment by 1 at posedge, modulo 2^16 (0xFFFF wraps to 0x0000). Bubbles (wb_valid=0) SHALL NOT count.
REQ-026 On retire & wb_is_wwd, output_port SHALL take wb_alu_result at posedge. It is visible from the next cycle and holds until the next WWD.
REQ-027 On retire & wb_is_halt, is_halted SHALL become 1 at posedge. The HLT itself SHALL be counted in num_inst.
REQ-028 While is_halted=1: no register writes, no num_inst change, no output_port change; read ports remain functional.
REQ-029 is_halted SHALL be cleared only by reset.
REQ-030 If wb_is_wwd and wb_reg_write are set in one entry, both effects SHALL occur in the same cycle.
REQ-031 If wb_is_halt is set with wb_is_wwd or wb_reg_write, only the halt and the count SHALL take effect.
REQ-032 Latency: one cycle from MEM/WB output to architectural state; zero cycles to the bypass and wb_data paths.

Reset
REQ-033 On posedge clk with reset_n=0, all registers, num_inst, output_port and is_halted SHALL become 0; all inputs are ignored that cycle.
REQ-034 Reset asserted mid-operation (including while halted) SHALL take priority over any retire in the same cycle.
REQ-035 In the first cycle after reset_n rises, the block SHALL accept a retire normally.

Verification
REQ-036 Reset, then valid write: dst=1, src=0, alu=0x1234 -> next cycle regs[1]=0x1234, num_inst=1; during the write cycle rd_addr1=1 reads 0x1234 (bypass).
REQ-037 Load, then JAL: src=1, mem=0xBEEF, dst=2; then src=2, pc=0x0031, dst=2 -> regs[2] reads 0xBEEF, then 0x0031; num_inst=2.
REQ-038 WWD alu=0x00A5, then bubble with alu=0xFFFF -> output_port=0x00A5 and stays; num_inst increments only once.
REQ-039 HLT with reg_write=1, dst=3, then a write of 0x7777 to r0 -> is_halted=1, regs[3] and r0 unchanged, num_inst counts the HLT only.
REQ-040 Preload num_inst=0xFFFF, then retire -> num_inst=0x0000; reset_n=0 while halted, same cycle as a retire -> all outputs 0 and is_halted=0.
